// File: rtl/instr_prefetch_queue_if.sv
// instr_prefetch_queue_if: fetch-stage bundle covering the memory instruction port, decode handshake, redirect and snoop
interface instr_prefetch_queue_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0]       Instruction_addressbus;
  logic [DATA_W-1:0]       Instruction_databus;
  logic                    instr_valid;
  logic                    instr_ready;
  logic [DATA_W-1:0]       instr_data;
  logic [ADDR_W-1:0]       instr_pc;
  logic                    redirect_valid;
  logic [ADDR_W-1:0]       redirect_pc;
  logic                    snoop_valid;
  logic [ADDR_W-1:0]       snoop_addr;
  logic [$clog2(DEPTH):0]  occupancy;
  modport master (
    output Instruction_addressbus, instr_valid, instr_data, instr_pc, occupancy,
    input  Instruction_databus, instr_ready, redirect_valid, redirect_pc, snoop_valid, snoop_addr
  );
  modport slave (
    input  Instruction_addressbus, instr_valid, instr_data, instr_pc, occupancy,
    output Instruction_databus, instr_ready, redirect_valid, redirect_pc, snoop_valid, snoop_addr
  );
endinterface

// File: rtl/instr_prefetch_queue.sv
// instr_prefetch_queue: prefetch FIFO of {pc, word} with redirect flush and self-modifying-code snoop flush
module instr_prefetch_queue #(
  parameter int               DEPTH    = 4,
  parameter int               ADDR_W   = 12,
  parameter int               DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic clk,
  input logic rst_n,
  instr_prefetch_queue_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d, refetch_pc;
  logic [PW-1:0]     rd_q, rd_d, wr_q, wr_d;
  logic [PW:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0] pc_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  hit_v;
  logic              valid, pop, push, hit, flush;
  assign valid = cnt_q != '0;
  assign pop   = valid && bus.instr_ready;
  genvar k;
  for (k = 0; k < DEPTH; k++) begin : g_hit
    assign hit_v[k] = (PW+1)'(k) < cnt_q && !(pop && k == 0) &&
                      pc_q[rd_q + PW'(k)][ADDR_W-1:1] == bus.snoop_addr[ADDR_W-1:1];
  end
  // the word on the bus right now is about to be captured, so it is stale too
  assign hit   = bus.snoop_valid && (|hit_v || fetch_pc_q[ADDR_W-1:1] == bus.snoop_addr[ADDR_W-1:1]);
  assign flush = bus.redirect_valid || hit;
  assign push  = !flush && (!cnt_q[PW] || pop);
  assign refetch_pc = (valid && !pop) ? pc_q[rd_q] :
                      (pop && cnt_q > (PW+1)'(1)) ? pc_q[rd_q + 1'b1] : fetch_pc_q;
  always_comb begin
    fetch_pc_d = bus.redirect_valid ? {bus.redirect_pc[ADDR_W-1:1], 1'b0} :
                 hit ? refetch_pc : push ? fetch_pc_q + ADDR_W'(2) : fetch_pc_q;
    rd_d  = flush ? '0 : rd_q + PW'(pop);
    wr_d  = flush ? '0 : wr_q + PW'(push);
    cnt_d = flush ? '0 : cnt_q + (PW+1)'(push) - (PW+1)'(pop);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= {RESET_PC[ADDR_W-1:1], 1'b0};
      rd_q       <= '0;
      wr_q       <= '0;
      cnt_q      <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      cnt_q      <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[wr_q]   <= fetch_pc_q;
      data_q[wr_q] <= bus.Instruction_databus;
    end
  end
  assign bus.Instruction_addressbus = fetch_pc_q;
  assign bus.instr_valid = valid;
  assign bus.instr_data  = valid ? data_q[rd_q] : '0;
  assign bus.instr_pc    = valid ? pc_q[rd_q] : '0;
  assign bus.occupancy   = cnt_q;
endmodule

// File: tb/tb_instr_prefetch_queue.sv
// tb_instr_prefetch_queue: directed scenarios against a behavioural instruction memory
module tb_instr_prefetch_queue;
  logic clk = 0;
  logic rst_n = 0;
  int total = 0;
  int bad = 0;
  logic [15:0] mem [0:2047];
  instr_prefetch_queue_if #(.DEPTH(4), .ADDR_W(12), .DATA_W(16)) bus ();
  instr_prefetch_queue #(.DEPTH(4), .ADDR_W(12), .DATA_W(16), .RESET_PC(12'h000)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  always #5 clk = ~clk;
  assign bus.Instruction_databus = mem[bus.Instruction_addressbus[11:1]];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2048; i++) mem[i] = 16'hD000;
    bus.instr_ready = 0; bus.redirect_valid = 0; bus.redirect_pc = '0;
    bus.snoop_valid = 0; bus.snoop_addr = '0;
    rst_n = 0;
    step();
    total++; if (bus.Instruction_addressbus !== 12'h000) begin bad++; $display("FAIL rst_addr got=%h exp=000", bus.Instruction_addressbus); end
    total++; if (bus.occupancy !== 3'd0) begin bad++; $display("FAIL rst_occ got=%0d exp=0", bus.occupancy); end
    total++; if (bus.instr_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", bus.instr_valid); end
    total++; if (bus.instr_data !== 16'h0 || bus.instr_pc !== 12'h0) begin bad++; $display("FAIL rst_head got=%h/%h exp=0/0", bus.instr_data, bus.instr_pc); end
    rst_n = 1;
    for (int i = 1; i <= 5; i++) begin
      step();
      total++;
      if (bus.Instruction_addressbus !== 12'(i < 4 ? 2 * i : 8)) begin
        bad++; $display("FAIL fill_addr[%0d] got=%h exp=%h", i, bus.Instruction_addressbus, 12'(i < 4 ? 2 * i : 8));
      end
    end
    total++; if (bus.occupancy !== 3'd4) begin bad++; $display("FAIL fill_occ got=%0d exp=4", bus.occupancy); end
    total++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 12'h000 || bus.instr_data !== 16'hD000) begin
      bad++; $display("FAIL fill_head got=%b/%h/%h exp=1/000/d000", bus.instr_valid, bus.instr_pc, bus.instr_data);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 2048; i++) mem[i] = 16'h1000 + 16'(2 * i);
    bus.instr_ready = 1;
    for (int i = 0; i < 8; i++) begin
      total++; if (bus.instr_pc !== 12'(2 * i)) begin bad++; $display("FAIL b2b_pc[%0d] got=%h exp=%h", i, bus.instr_pc, 12'(2 * i)); end
      total++; if (bus.Instruction_addressbus !== 12'(8 + 2 * i) || bus.occupancy !== 3'd4) begin
        bad++; $display("FAIL b2b_addr_occ[%0d] got=%h/%0d exp=%h/4", i, bus.Instruction_addressbus, bus.occupancy, 12'(8 + 2 * i));
      end
      total++; if (bus.instr_data !== (i < 4 ? 16'hD000 : 16'h1000 + 16'(2 * i))) begin
        bad++; $display("FAIL b2b_data[%0d] got=%h", i, bus.instr_data);
      end
      step();
    end
    bus.instr_ready = 0;
  endtask

  task automatic test_snoop();
    bus.snoop_valid = 1; bus.snoop_addr = 12'h015;
    step();
    mem[12'h014 >> 1] = 16'hBEEF;
    bus.snoop_valid = 0;
    total++; if (bus.occupancy !== 3'd0 || bus.instr_valid !== 1'b0 || bus.Instruction_addressbus !== 12'h010) begin
      bad++; $display("FAIL snoop_nopop got=%0d/%b/%h exp=0/0/010", bus.occupancy, bus.instr_valid, bus.Instruction_addressbus);
    end
    step();
    total++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 12'h010 || bus.instr_data !== 16'h1010) begin
      bad++; $display("FAIL snoop_refetch got=%b/%h/%h exp=1/010/1010", bus.instr_valid, bus.instr_pc, bus.instr_data);
    end
    repeat (3) step();
    total++; if (bus.occupancy !== 3'd4 || bus.Instruction_addressbus !== 12'h018) begin
      bad++; $display("FAIL snoop_refill got=%0d/%h exp=4/018", bus.occupancy, bus.Instruction_addressbus);
    end
    bus.snoop_valid = 1; bus.instr_ready = 1;
    step();
    bus.snoop_valid = 0; bus.instr_ready = 0;
    total++; if (bus.occupancy !== 3'd0 || bus.Instruction_addressbus !== 12'h012) begin
      bad++; $display("FAIL snoop_pop got=%0d/%h exp=0/012", bus.occupancy, bus.Instruction_addressbus);
    end
    step();
    total++; if (bus.instr_pc !== 12'h012 || bus.instr_data !== 16'h1012 || bus.occupancy !== 3'd1) begin
      bad++; $display("FAIL snoop_pop_head got=%h/%h/%0d exp=012/1012/1", bus.instr_pc, bus.instr_data, bus.occupancy);
    end
    bus.instr_ready = 1;
    step();
    bus.instr_ready = 0;
    total++; if (bus.instr_pc !== 12'h014 || bus.instr_data !== 16'hBEEF || bus.Instruction_addressbus !== 12'h016) begin
      bad++; $display("FAIL snoop_newword got=%h/%h/%h exp=014/beef/016", bus.instr_pc, bus.instr_data, bus.Instruction_addressbus);
    end
    repeat (3) step();
    bus.snoop_valid = 1; bus.snoop_addr = 12'h400;
    step();
    total++; if (bus.occupancy !== 3'd4 || bus.Instruction_addressbus !== 12'h01C || bus.instr_pc !== 12'h014) begin
      bad++; $display("FAIL snoop_miss got=%0d/%h/%h exp=4/01c/014", bus.occupancy, bus.Instruction_addressbus, bus.instr_pc);
    end
    bus.snoop_addr = 12'h01D;
    step();
    bus.snoop_valid = 0;
    total++; if (bus.occupancy !== 3'd0 || bus.Instruction_addressbus !== 12'h014) begin
      bad++; $display("FAIL snoop_fetchpc got=%0d/%h exp=0/014", bus.occupancy, bus.Instruction_addressbus);
    end
  endtask

  task automatic test_redirect();
    bus.redirect_valid = 1; bus.redirect_pc = 12'h100;
    step();
    bus.redirect_valid = 0;
    total++; if (bus.occupancy !== 3'd0 || bus.Instruction_addressbus !== 12'h100) begin
      bad++; $display("FAIL redir1 got=%0d/%h exp=0/100", bus.occupancy, bus.Instruction_addressbus);
    end
    repeat (3) step();
    total++; if (bus.occupancy !== 3'd3 || bus.instr_pc !== 12'h100 || bus.instr_data !== 16'h1100) begin
      bad++; $display("FAIL redir_fill got=%0d/%h/%h exp=3/100/1100", bus.occupancy, bus.instr_pc, bus.instr_data);
    end
    bus.redirect_valid = 1; bus.redirect_pc = 12'h321; bus.instr_ready = 1;
    step();
    bus.redirect_valid = 0; bus.instr_ready = 0;
    total++; if (bus.occupancy !== 3'd0 || bus.instr_valid !== 1'b0 || bus.Instruction_addressbus !== 12'h320) begin
      bad++; $display("FAIL redir2 got=%0d/%b/%h exp=0/0/320", bus.occupancy, bus.instr_valid, bus.Instruction_addressbus);
    end
    step();
    total++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 12'h320 || bus.instr_data !== 16'h1320) begin
      bad++; $display("FAIL redir2_head got=%b/%h/%h exp=1/320/1320", bus.instr_valid, bus.instr_pc, bus.instr_data);
    end
  endtask

  task automatic test_wrap();
    bus.redirect_valid = 1; bus.redirect_pc = 12'hFFD;
    step();
    bus.redirect_valid = 0;
    total++; if (bus.Instruction_addressbus !== 12'hFFC) begin bad++; $display("FAIL wrap0 got=%h exp=ffc", bus.Instruction_addressbus); end
    step();
    step();
    total++; if (bus.Instruction_addressbus !== 12'h000 || bus.occupancy !== 3'd2) begin
      bad++; $display("FAIL wrap1 got=%h/%0d exp=000/2", bus.Instruction_addressbus, bus.occupancy);
    end
    total++; if (bus.instr_pc !== 12'hFFC || bus.instr_data !== 16'h1FFC) begin
      bad++; $display("FAIL wrap_head got=%h/%h exp=ffc/1ffc", bus.instr_pc, bus.instr_data);
    end
    step();
    total++; if (bus.Instruction_addressbus !== 12'h002) begin bad++; $display("FAIL wrap2 got=%h exp=002", bus.Instruction_addressbus); end
  endtask

  task automatic test_async_reset();
    bus.instr_ready = 1;
    step();
    #2 rst_n = 0;
    #1;
    total++; if (bus.Instruction_addressbus !== 12'h000 || bus.occupancy !== 3'd0) begin
      bad++; $display("FAIL arst_addr_occ got=%h/%0d exp=000/0", bus.Instruction_addressbus, bus.occupancy);
    end
    total++; if (bus.instr_valid !== 1'b0 || bus.instr_pc !== 12'h0 || bus.instr_data !== 16'h0) begin
      bad++; $display("FAIL arst_head got=%b/%h/%h exp=0/000/0000", bus.instr_valid, bus.instr_pc, bus.instr_data);
    end
    bus.instr_ready = 0;
    step();
    rst_n = 1;
    step();
    total++; if (bus.Instruction_addressbus !== 12'h002 || bus.instr_pc !== 12'h000) begin
      bad++; $display("FAIL arst_restart got=%h/%h exp=002/000", bus.Instruction_addressbus, bus.instr_pc);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_snoop();
    test_redirect();
    test_wrap();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
